sad_best_match_tracker: RTL
===========================

Name: sad_best_match_tracker

Overview:
- Consumer end of the SAD1→SAD2 pipeline register.
- Takes the 16 registered 14-bit per-row SAD partials, one candidate per cycle, each with its 16-bit candidate index and the TriggerBoss end-of-search flag.
- Reduces the partials to a full-block SAD and tracks the minimum SAD and its index across the search window.
- When the TriggerBoss candidate retires, presents the best match on a valid/ready result interface.

Parameters:
- LANES, 16, number of SAD partial lanes per candidate (fixed; bench uses 16)
- LANE_W, 14, width of each partial
- IDX_W, 16, width of candidate index
- SUM_W, 18, width of total SAD (16 × 16383 = 262128 fits in 18 bits)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- SAD2_valid  in  1  candidate present this cycle
- SAD2_Index  in  16  candidate index
- SAD2_TriggerBoss  in  1  last candidate of current search
- SAD2_inputs  in  224  flattened partials; lane k (1..16) at bits [14k-1:14k-14]
- best_valid  out  1  result available
- best_ready  in  1  downstream accepts result
- best_sad  out  18  minimum total SAD of completed search
- best_index  out  16  index of that minimum
- cand_count  out  16  candidates counted in completed search
- overrun  out  1  sticky; result lost before acceptance

Behaviour:
- Reset: rst_n=0 at a rising edge clears every pipeline valid bit, running_min=18'h3FFFF, running_idx=0, running_cnt=0, best_valid=0, best_sad=0, best_index=0, cand_count=0, overrun=0. A reset mid-search discards all in-flight candidates; no result is produced for them.
- Stage S1 (edge E0):
  - If SAD2_valid, register four 16-bit quad sums (lanes 1-4, 5-8, 9-12, 13-16), plus index and trigger; v1 <= SAD2_valid.
  - SAD2_TriggerBoss is ignored when SAD2_valid=0.
- Stage S2 (edge E1): total = sum of the four quads (18-bit, zero-extended, no saturation); register it with index and trigger; v2 <= v1.
- Stage S3 (edge E2), when v2=1:
  - Compare running value against total: new_min = (total < running_min) ? total : running_min. Strictly less, so on ties the earliest index is kept. new_idx follows the same selection. running_cnt+1 is used.
  - If trigger2=0: running_min, running_idx and running_cnt take the new values.
  - If trigger2=1: load best_sad=new_min, best_index=new_idx, cand_count=running_cnt+1, and set best_valid=1. Then reset running_min=3FFFF, running_idx=0, running_cnt=0 so a new search can start on the very next candidate with no bubble.
- Latency: a candidate presented before edge E0 affects outputs after edge E2. best_valid rises after edge E2 of the trigger candidate (3 edges).
- Throughput: one candidate per cycle, no stall. Bubbles (SAD2_valid=0) are allowed anywhere.
- Result handshake:
  - best_valid stays high and best_* stay stable until an edge with best_valid=1 and best_ready=1. That edge clears best_valid unless a new result loads on the same edge, in which case the new result is loaded and best_valid stays 1.
  - A new result loading while best_valid=1 and best_ready=0: the new result overwrites the old one and overrun is set. overrun is cleared only by reset.
- Single-candidate search (trigger on first candidate): result = that candidate's total, cand_count=1.
- All-maximum partials: total = 262128; this is below the 3FFFF sentinel, so it is still captured.
- running_cnt wraps at 16 bits without a flag.

Test Plan:
- Single candidate: all lanes = 100, Index=7, trigger=1, best_ready=0 → 3 edges later best_valid=1, best_sad=1600, best_index=7, cand_count=1; values held until best_ready=1, then best_valid=0 on the next edge.
- Min search with tie: indices 0..4 with totals 500, 300, 800, 300, 900 (trigger on index 4), SAD2_valid high throughout → best_sad=300, best_index=1, cand_count=5.
- Back-to-back searches with bubbles: search A {10:400, 11:200(trig)}, one idle cycle, search B {20:50(trig)}, best_ready=1 always → result A (200, 11, 2), then result B (50, 20, 1); no carry-over of A's minimum into B; overrun=0.
- Overrun: two single-candidate searches completing with best_ready=0 → second result replaces the first and overrun=1; it stays 1 after acceptance until rst_n=0.
- Saturation boundary: all lanes = 16383, trigger=1 → best_sad=262128, no wrap.
- Reset mid-search: 3 candidates with no trigger, then rst_n=0 for one edge, then a single candidate total=900 with trigger → best_sad=900, cand_count=1; a prior lower SAD of 100 is not reported.

Source files
------------

// File: rtl/sad_best_match_tracker.sv
// Final SAD stage: reduces per-row partials to a block SAD, tracks the
// minimum across a search window and hands the winner out on valid/ready.
module sad_best_match_tracker #(
    parameter int unsigned LANES  = 16,
    parameter int unsigned LANE_W = 14,
    parameter int unsigned IDX_W  = 16,
    parameter int unsigned SUM_W  = 18
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      SAD2_valid,
    input  logic [IDX_W-1:0]          SAD2_Index,
    input  logic                      SAD2_TriggerBoss,
    input  logic [LANES*LANE_W-1:0]   SAD2_inputs,
    output logic                      best_valid,
    input  logic                      best_ready,
    output logic [SUM_W-1:0]          best_sad,
    output logic [IDX_W-1:0]          best_index,
    output logic [IDX_W-1:0]          cand_count,
    output logic                      overrun
);

    localparam int unsigned NQ     = LANES / 4;
    localparam int unsigned QUAD_W = LANE_W + 2;

    // S1: quad sums
    logic [NQ-1:0][QUAD_W-1:0] quad_d, quad_q;
    logic                      v1_q, trig1_q;
    logic [IDX_W-1:0]          idx1_q;

    // S2: full-block total
    logic [SUM_W-1:0]          total_d, total_q;
    logic                      v2_q, trig2_q;
    logic [IDX_W-1:0]          idx2_q;

    // S3: running search state and result registers
    logic [SUM_W-1:0]          run_min_d, run_min_q;
    logic [IDX_W-1:0]          run_idx_d, run_idx_q;
    logic [IDX_W-1:0]          run_cnt_d, run_cnt_q;
    logic [SUM_W-1:0]          best_sad_d, best_sad_q;
    logic [IDX_W-1:0]          best_idx_d, best_idx_q;
    logic [IDX_W-1:0]          cand_cnt_d, cand_cnt_q;
    logic                      best_valid_d, best_valid_q;
    logic                      overrun_d, overrun_q;

    logic                      take_new, done;
    logic [SUM_W-1:0]          new_min;
    logic [IDX_W-1:0]          new_idx, cnt_inc;

    always_comb begin
        quad_d = '0;
        for (int unsigned q = 0; q < NQ; q++) begin
            for (int unsigned l = 0; l < 4; l++) begin
                quad_d[q] = quad_d[q]
                          + QUAD_W'(SAD2_inputs[(4*q+l)*LANE_W +: LANE_W]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
        end else begin
            v1_q <= SAD2_valid;
            if (SAD2_valid) begin
                quad_q  <= quad_d;
                idx1_q  <= SAD2_Index;
                trig1_q <= SAD2_TriggerBoss;
            end
        end
    end

    always_comb begin
        total_d = '0;
        for (int unsigned q = 0; q < NQ; q++) begin
            total_d = total_d + SUM_W'(quad_q[q]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2_q <= 1'b0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                total_q <= total_d;
                idx2_q  <= idx1_q;
                trig2_q <= trig1_q;
            end
        end
    end

    // Strict less-than keeps the earliest index on ties.
    assign take_new = total_q < run_min_q;
    assign new_min  = take_new ? total_q : run_min_q;
    assign new_idx  = take_new ? idx2_q  : run_idx_q;
    assign cnt_inc  = run_cnt_q + 1'b1;
    assign done     = v2_q & trig2_q;

    always_comb begin
        run_min_d    = run_min_q;
        run_idx_d    = run_idx_q;
        run_cnt_d    = run_cnt_q;
        best_sad_d   = best_sad_q;
        best_idx_d   = best_idx_q;
        cand_cnt_d   = cand_cnt_q;
        best_valid_d = best_valid_q;
        overrun_d    = overrun_q;
        if (best_valid_q && best_ready) begin
            best_valid_d = 1'b0;
        end
        if (v2_q) begin
            if (done) begin
                best_sad_d   = new_min;
                best_idx_d   = new_idx;
                cand_cnt_d   = cnt_inc;
                best_valid_d = 1'b1;
                overrun_d    = overrun_q | (best_valid_q & ~best_ready);
                run_min_d    = '1;
                run_idx_d    = '0;
                run_cnt_d    = '0;
            end else begin
                run_min_d = new_min;
                run_idx_d = new_idx;
                run_cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_min_q    <= '1;
            run_idx_q    <= '0;
            run_cnt_q    <= '0;
            best_sad_q   <= '0;
            best_idx_q   <= '0;
            cand_cnt_q   <= '0;
            best_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            run_min_q    <= run_min_d;
            run_idx_q    <= run_idx_d;
            run_cnt_q    <= run_cnt_d;
            best_sad_q   <= best_sad_d;
            best_idx_q   <= best_idx_d;
            cand_cnt_q   <= cand_cnt_d;
            best_valid_q <= best_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign best_valid = best_valid_q;
    assign best_sad   = best_sad_q;
    assign best_index = best_idx_q;
    assign cand_count = cand_cnt_q;
    assign overrun    = overrun_q;

endmodule
